// File: rtl/risc_control_unit.sv
// Sequencing control unit for the single-cycle RISC datapath: IDLE/CLEAR/RUN/HALT
// plus a combinational instruction decoder, a latched {C,V,Z,N} status register and a run watchdog.
module risc_control_unit #(
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        Pre_C,
    input  logic        Pre_V,
    input  logic        Pre_Z,
    input  logic        Pre_N,
    output logic        test_normal,
    output logic        clr,
    output logic        flag_HLT,
    output logic        Src_Read_B,
    output logic        Src_ALU_B,
    output logic        ADC,
    output logic        SUB,
    output logic        SBB,
    output logic        JMP,
    output logic        BRANCH,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic        flag_Rd_PC,
    output logic        data_write_en,
    output logic        RF_write_en,
    output logic        flag_mem_RF,
    output logic        flag_ALU_RF,
    output logic        flag_Rm_RF,
    output logic        flag_PC_RF,
    output logic        LHI,
    output logic        LLI,
    output logic        flag_OutR,
    output logic [3:0]  status,
    output logic        halted,
    output logic        timeout,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [4:0] OP_ALUR = 5'b00000;
    localparam logic [4:0] OP_LLI  = 5'b00001;
    localparam logic [4:0] OP_LHI  = 5'b00010;
    localparam logic [4:0] OP_LDR  = 5'b00011;
    localparam logic [4:0] OP_STR  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_JAL  = 5'b10001;
    localparam logic [4:0] OP_JR   = 5'b10010;
    localparam logic [4:0] OP_BCC  = 5'b11000;
    localparam logic [4:0] OP_OUT  = 5'b11100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    state_t      state_q, state_d;
    logic [3:0]  status_q, status_d;
    logic [15:0] count_q, count_d;
    logic        timeout_q, timeout_d;

    logic [4:0]  opcode;
    logic [2:0]  cond;
    logic [1:0]  alu_var;
    logic [15:0] count_inc;
    logic        count_sat;
    logic        cond_met;
    logic        unused_instr;

    assign opcode       = instr[15:11];
    assign cond         = instr[10:8];
    assign alu_var      = instr[1:0];
    assign count_inc    = count_q + 16'd1;
    assign count_sat    = (count_q == 16'hFFFF);
    assign unused_instr = ^instr[7:2];

    assign status      = status_q;
    assign instr_count = count_q;
    assign timeout     = timeout_q;

    // status_q is {C,V,Z,N}; branches test the flags latched by the last ALU op
    always_comb begin
        cond_met = 1'b0;
        case (cond)
            3'b000:  cond_met =  status_q[1];
            3'b001:  cond_met = ~status_q[1];
            3'b010:  cond_met =  status_q[3];
            3'b011:  cond_met = ~status_q[3];
            3'b100:  cond_met =  status_q[0];
            3'b101:  cond_met = ~status_q[0];
            3'b110:  cond_met =  status_q[2];
            default: cond_met = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            status_q  <= 4'b0000;
            count_q   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        count_d       = count_q;
        timeout_d     = timeout_q;
        test_normal   = 1'b1;
        clr           = 1'b0;
        flag_HLT      = 1'b0;
        halted        = 1'b0;
        Src_Read_B    = 1'b0;
        Src_ALU_B     = 1'b0;
        ADC           = 1'b0;
        SUB           = 1'b0;
        SBB           = 1'b0;
        JMP           = 1'b0;
        BRANCH        = 1'b0;
        flag_label_PC = 1'b0;
        flag_Rm_PC    = 1'b0;
        flag_Rd_PC    = 1'b0;
        data_write_en = 1'b0;
        RF_write_en   = 1'b0;
        flag_mem_RF   = 1'b0;
        flag_ALU_RF   = 1'b0;
        flag_Rm_RF    = 1'b0;
        flag_PC_RF    = 1'b0;
        LHI           = 1'b0;
        LLI           = 1'b0;
        flag_OutR     = 1'b0;

        // Held in reset: the register bank resets at the edge, the gate keeps
        // write strobes low during the reset cycle itself.
        if (clr_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    test_normal = 1'b0;
                    clr         = 1'b1;
                    count_d     = 16'd0;
                    status_d    = 4'b0000;
                    timeout_d   = 1'b0;
                    state_d     = ST_RUN;
                end
                ST_RUN: begin
                    test_normal = 1'b0;
                    flag_HLT    = 1'b1;
                    case (opcode)
                        OP_ALUR: begin
                            flag_ALU_RF = 1'b1;
                            RF_write_en = 1'b1;
                            SUB         = (alu_var == 2'b10);
                            ADC         = (alu_var == 2'b01);
                            SBB         = (alu_var == 2'b11);
                            status_d    = {Pre_C, Pre_V, Pre_Z, Pre_N};
                        end
                        OP_LLI: begin
                            LLI         = 1'b1;
                            RF_write_en = 1'b1;
                        end
                        OP_LHI: begin
                            LHI         = 1'b1;
                            Src_Read_B  = 1'b1;
                            RF_write_en = 1'b1;
                        end
                        OP_LDR: begin
                            Src_ALU_B   = 1'b1;
                            flag_mem_RF = 1'b1;
                            RF_write_en = 1'b1;
                        end
                        OP_STR: begin
                            Src_ALU_B     = 1'b1;
                            Src_Read_B    = 1'b1;
                            data_write_en = 1'b1;
                        end
                        OP_ADDI: begin
                            Src_ALU_B   = 1'b1;
                            flag_ALU_RF = 1'b1;
                            RF_write_en = 1'b1;
                            status_d    = {Pre_C, Pre_V, Pre_Z, Pre_N};
                        end
                        OP_JMP: begin
                            JMP           = 1'b1;
                            flag_label_PC = 1'b1;
                        end
                        OP_JAL: begin
                            JMP           = 1'b1;
                            flag_label_PC = 1'b1;
                            flag_PC_RF    = 1'b1;
                            RF_write_en   = 1'b1;
                        end
                        OP_JR: begin
                            JMP        = 1'b1;
                            flag_Rd_PC = 1'b1;
                        end
                        OP_BCC: begin
                            flag_label_PC = 1'b1;
                            BRANCH        = cond_met;
                        end
                        OP_OUT: begin
                            flag_OutR = 1'b1;
                        end
                        OP_HLT: begin
                            flag_HLT = 1'b0;
                            state_d  = ST_HALT;
                        end
                        default: ;
                    endcase

                    // Watchdog only redirects the state; the decoded controls above still apply.
                    if (opcode != OP_HLT && !count_sat) begin
                        count_d = count_inc;
                        if (WDOG_LIMIT != 16'd0 && count_inc == WDOG_LIMIT) begin
                            state_d   = ST_HALT;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                    if (start) state_d = ST_CLEAR;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit: reset, run/halt sequencing, flags/branch,
// decode, watchdog (limit 4) and mid-run reset, with hand-computed expectations.
module tb_risc_control_unit;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [15:0] instr;
    logic        pre_c, pre_v, pre_z, pre_n;
    logic        test_normal, clr, flag_HLT;
    logic        Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH;
    logic        flag_label_PC, flag_Rm_PC, flag_Rd_PC;
    logic        data_write_en, RF_write_en, flag_mem_RF, flag_ALU_RF;
    logic        flag_Rm_RF, flag_PC_RF, LHI, LLI, flag_OutR;
    logic [3:0]  status;
    logic        halted, timeout;
    logic [15:0] instr_count;
    logic [18:0] ctrl;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [18:0] K_SRB  = 19'h40000;
    localparam logic [18:0] K_SAB  = 19'h20000;
    localparam logic [18:0] K_SUB  = 19'h08000;
    localparam logic [18:0] K_JMP  = 19'h02000;
    localparam logic [18:0] K_BR   = 19'h01000;
    localparam logic [18:0] K_LPC  = 19'h00800;
    localparam logic [18:0] K_DWE  = 19'h00100;
    localparam logic [18:0] K_RFW  = 19'h00080;
    localparam logic [18:0] K_MRF  = 19'h00040;
    localparam logic [18:0] K_ARF  = 19'h00020;
    localparam logic [18:0] K_PCRF = 19'h00008;
    localparam logic [18:0] K_OUTR = 19'h00001;

    localparam logic [15:0] I_LDR   = 16'h1A23;
    localparam logic [15:0] I_OUT   = 16'hE010;
    localparam logic [15:0] I_HLT   = 16'hF800;
    localparam logic [15:0] I_SUB   = 16'h0346;
    localparam logic [15:0] I_BZ    = 16'hC004;
    localparam logic [15:0] I_BC    = 16'hC204;
    localparam logic [15:0] I_ADDI  = 16'h3A27;
    localparam logic [15:0] I_STR   = 16'h2A41;
    localparam logic [15:0] I_JAL   = 16'h8812;
    localparam logic [15:0] I_NOP   = 16'h4000;

    assign ctrl = {Src_Read_B, Src_ALU_B, ADC, SUB, SBB, JMP, BRANCH, flag_label_PC,
                   flag_Rm_PC, flag_Rd_PC, data_write_en, RF_write_en, flag_mem_RF,
                   flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI, flag_OutR};

    risc_control_unit #(.WDOG_LIMIT(16'd4)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .instr(instr),
        .Pre_C(pre_c), .Pre_V(pre_v), .Pre_Z(pre_z), .Pre_N(pre_n),
        .test_normal(test_normal), .clr(clr), .flag_HLT(flag_HLT),
        .Src_Read_B(Src_Read_B), .Src_ALU_B(Src_ALU_B), .ADC(ADC), .SUB(SUB), .SBB(SBB),
        .JMP(JMP), .BRANCH(BRANCH), .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
        .flag_Rd_PC(flag_Rd_PC), .data_write_en(data_write_en), .RF_write_en(RF_write_en),
        .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF), .flag_Rm_RF(flag_Rm_RF),
        .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI), .flag_OutR(flag_OutR),
        .status(status), .halted(halted), .timeout(timeout), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [15:0] v);
        instr = v;
        #1;
    endtask

    // From RUN: execute HLT, then restart through CLEAR back into RUN.
    task automatic restart();
        apply(I_HLT);
        tick();
        chk("restart_halted", {31'd0, halted}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_clr", {31'd0, clr}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        clr_n = 1'b0; start = 1'b1; instr = 16'h0000;
        pre_c = 1'b0; pre_v = 1'b0; pre_z = 1'b0; pre_n = 1'b0;

        // Reset held two cycles with start asserted
        tick();
        tick();
        chk("rst_test_normal", {31'd0, test_normal}, 32'd1);
        chk("rst_flag_HLT",    {31'd0, flag_HLT},    32'd0);
        chk("rst_ctrl",        {13'd0, ctrl},        32'd0);
        chk("rst_clr",         {31'd0, clr},         32'd0);
        chk("rst_status",      {28'd0, status},      32'd0);
        chk("rst_count",       {16'd0, instr_count}, 32'd0);
        chk("rst_timeout",     {31'd0, timeout},     32'd0);
        clr_n = 1'b1; start = 1'b0;
        tick();
        tick();
        chk("idle_test_normal", {31'd0, test_normal}, 32'd1);
        chk("idle_clr",         {31'd0, clr},         32'd0);
        chk("idle_halted",      {31'd0, halted},      32'd0);

        // Load, run, halt: LDR, OUT, HLT
        start = 1'b1;
        #1;
        chk("idle_start_noclr", {31'd0, clr}, 32'd0);
        tick();
        start = 1'b0;
        chk("clear_clr",    {31'd0, clr},         32'd1);
        chk("clear_tn",     {31'd0, test_normal}, 32'd0);
        chk("clear_hlt",    {31'd0, flag_HLT},    32'd0);
        tick();
        apply(I_LDR);
        chk("ldr_clr_once", {31'd0, clr},      32'd0);
        chk("ldr_ctrl",     {13'd0, ctrl},     {13'd0, K_SAB | K_MRF | K_RFW});
        chk("ldr_flag_HLT", {31'd0, flag_HLT}, 32'd1);
        tick();
        apply(I_OUT);
        chk("out_ctrl",  {13'd0, ctrl},        {13'd0, K_OUTR});
        chk("out_count", {16'd0, instr_count}, 32'd1);
        tick();
        apply(I_HLT);
        chk("hlt_flag_HLT", {31'd0, flag_HLT}, 32'd0);
        chk("hlt_ctrl",     {13'd0, ctrl},     32'd0);
        tick();
        chk("halt_halted", {31'd0, halted},      32'd1);
        chk("halt_count",  {16'd0, instr_count}, 32'd2);
        chk("halt_tn",     {31'd0, test_normal}, 32'd1);

        // Flags and branch: SUB sets Z, BZ taken
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("clear2_count", {16'd0, instr_count}, 32'd2);
        tick();
        chk("run2_count", {16'd0, instr_count}, 32'd0);
        pre_z = 1'b1;
        apply(I_SUB);
        chk("sub_ctrl", {13'd0, ctrl}, {13'd0, K_SUB | K_ARF | K_RFW});
        tick();
        pre_z = 1'b0;
        apply(I_BZ);
        chk("bz_status", {28'd0, status}, 32'h2);
        chk("bz_taken",  {13'd0, ctrl},   {13'd0, K_LPC | K_BR});
        restart();

        // SUB with Z=0, C=1: BZ not taken, BC taken
        pre_c = 1'b1;
        apply(I_SUB);
        tick();
        pre_c = 1'b0;
        apply(I_BZ);
        chk("bz2_status",   {28'd0, status}, 32'h8);
        chk("bz2_nottaken", {13'd0, ctrl},   {13'd0, K_LPC});
        tick();
        apply(I_BC);
        chk("bc_taken", {13'd0, ctrl}, {13'd0, K_LPC | K_BR});
        tick();
        chk("bc_status_held", {28'd0, status}, 32'h8);
        restart();

        // Decode: ADDI, STR, JAL
        apply(I_ADDI);
        chk("addi_ctrl", {13'd0, ctrl}, {13'd0, K_SAB | K_ARF | K_RFW});
        tick();
        apply(I_STR);
        chk("str_ctrl", {13'd0, ctrl},        {13'd0, K_SAB | K_SRB | K_DWE});
        chk("str_rfw",  {31'd0, RF_write_en}, 32'd0);
        tick();
        apply(I_JAL);
        chk("jal_ctrl", {13'd0, ctrl}, {13'd0, K_JMP | K_LPC | K_PCRF | K_RFW});
        tick();
        restart();

        // Watchdog at limit 4 with a NOP loop
        apply(I_NOP);
        chk("nop_ctrl", {13'd0, ctrl}, 32'd0);
        tick();
        tick();
        tick();
        chk("wd_pre_count",  {16'd0, instr_count}, 32'd3);
        chk("wd_pre_halted", {31'd0, halted},      32'd0);
        tick();
        chk("wd_halted",  {31'd0, halted},      32'd1);
        chk("wd_timeout", {31'd0, timeout},     32'd1);
        chk("wd_count",   {16'd0, instr_count}, 32'd4);
        chk("wd_hlt",     {31'd0, flag_HLT},    32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("wd_clear_timeout", {31'd0, timeout}, 32'd1);
        tick();
        chk("wd_run_timeout", {31'd0, timeout},     32'd0);
        chk("wd_run_count",   {16'd0, instr_count}, 32'd0);

        // Mid-run reset during a store
        pre_n = 1'b1;
        apply(I_SUB);
        tick();
        pre_n = 1'b0;
        apply(I_STR);
        chk("mr_status",  {28'd0, status},        32'h1);
        chk("mr_str_dwe", {31'd0, data_write_en}, 32'd1);
        clr_n = 1'b0;
        #1;
        chk("mr_rstcycle_dwe", {31'd0, data_write_en}, 32'd0);
        tick();
        chk("mr_after_dwe",    {31'd0, data_write_en}, 32'd0);
        chk("mr_after_status", {28'd0, status},        32'd0);
        chk("mr_after_tn",     {31'd0, test_normal},   32'd1);
        chk("mr_after_count",  {16'd0, instr_count},   32'd0);
        clr_n = 1'b1;
        tick();
        chk("mr_idle_hlt", {31'd0, flag_HLT}, 32'd0);
        chk("mr_idle_clr", {31'd0, clr},      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
